// File: rtl/trolley_system_button_in.sv
// Avalon-MM push-button input port: sync, optional debounce, edge capture, level IRQ.
// Define TROLLEY_BUTTON_DEBOUNCE_EN to add per-bit debounce counters.
module trolley_system_button_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] s1, s2, db, db_d;
    logic [WIDTH-1:0] irq_mask, edge_capture, edge_vec, clr;
    logic             wr;
    logic [31:0]      rd_mux;
    logic [31:0]      unused_wd;

    assign unused_wd = writedata;
    assign wr        = chipselect & ~write_n;
    assign clr       = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= IDLE;
            s2   <= IDLE;
            db_d <= IDLE;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            db_d <= db;
        end
    end

`ifdef TROLLEY_BUTTON_DEBOUNCE_EN
    localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    // A bit only moves once s2 has disagreed with it for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (reset) begin
                cnt[i] <= '0;
                db[i]  <= IDLE_LEVEL;
            end else if (s2[i] == db[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CMAX) begin
                cnt[i] <= '0;
                db[i]  <= s2[i];
            end else begin
                cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) db <= IDLE;
        else       db <= s2;
    end
`endif

    always_comb begin
        edge_vec = db ^ db_d;
        if (EDGE_TYPE == 0)      edge_vec = db & ~db_d;
        else if (EDGE_TYPE == 1) edge_vec = ~db & db_d;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = db;
            2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    // New edges are OR-ed in after the clear so a same-cycle set survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            readdata     <= rd_mux;
            edge_capture <= (edge_capture & ~clr) | edge_vec;
            if (wr && address == 2'd2)
                irq_mask <= writedata[WIDTH-1:0];
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_trolley_system_button_in.sv
// Self-checking bench for trolley_system_button_in (WIDTH=4, falling-edge capture).
// Define TROLLEY_BUTTON_DEBOUNCE_EN to exercise the debounce build.
module tb_trolley_system_button_in;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trolley_system_button_in #(
        .WIDTH(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    typedef struct {
        logic [3:0]  ip;
        logic [1:0]  a;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        irq;
    } vec_t;

    vec_t tbl[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] ip, input logic [1:0] a,
                        input logic cs, input logic wn, input logic [31:0] wd);
        in_port    = ip;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] ip, input logic [1:0] a, input logic wr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic iq);
        vec_t v;
        v.ip = ip; v.a = a; v.wr = wr; v.wd = wd; v.rd = rd; v.irq = iq;
        tbl.push_back(v);
    endtask

    // Reference: DATA is the input seen through a two-clock delay line,
    // and the capture register collects falling transitions of DATA.
    logic [3:0]  dl[4];
    logic [3:0]  m_mask, m_cap, r_ip;
    logic [31:0] m_rd;

    task automatic model_edge(input logic rst, input logic [3:0] ip, input logic [1:0] a,
                              input logic cs, input logic wn, input logic [31:0] wd);
        logic [3:0] data, fell, clr;
        if (rst) begin
            for (int i = 0; i < 4; i++) dl[i] = 4'hF;
            m_mask = '0;
            m_cap  = '0;
            m_rd   = '0;
        end else begin
            data = dl[2];
            fell = ~dl[2] & dl[3];
            m_rd = (a == 2'd0) ? {28'd0, data} :
                   (a == 2'd2) ? {28'd0, m_mask} :
                   (a == 2'd3) ? {28'd0, m_cap} : 32'd0;
            clr  = (cs && !wn && a == 2'd3) ? wd[3:0] : 4'd0;
            m_cap = (m_cap & ~clr) | fell;
            if (cs && !wn && a == 2'd2) m_mask = wd[3:0];
            dl[3] = dl[2];
            dl[2] = dl[1];
            dl[1] = dl[0];
            dl[0] = ip;
        end
    endtask

    initial begin
        reset = 1'b1;
        step(4'hF, 2'd0, 1'b0, 1'b1, 32'd0);
        step(4'hF, 2'd0, 1'b0, 1'b1, 32'd0);
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;

`ifndef TROLLEY_BUTTON_DEBOUNCE_EN
        add(4'hF, 0, 0, 0, 32'hF, 0);
        add(4'hF, 3, 0, 0, 32'h0, 0);
        add(4'hF, 2, 1, 1, 32'h0, 0);
        add(4'hE, 2, 0, 0, 32'h1, 0);
        add(4'hE, 0, 0, 0, 32'hF, 0);
        add(4'hE, 0, 0, 0, 32'hF, 0);
        add(4'hE, 3, 0, 0, 32'h0, 1);
        add(4'hE, 0, 0, 0, 32'hE, 1);
        add(4'hE, 3, 1, 1, 32'h1, 0);
        add(4'hE, 3, 0, 0, 32'h0, 0);
        add(4'hE, 2, 1, 0, 32'h1, 0);
        add(4'hA, 0, 0, 0, 32'hE, 0);
        add(4'hA, 0, 0, 0, 32'hE, 0);
        add(4'hA, 0, 0, 0, 32'hE, 0);
        add(4'hA, 3, 0, 0, 32'h0, 0);
        add(4'hA, 3, 0, 0, 32'h4, 0);
        add(4'hA, 2, 1, 4, 32'h0, 1);
        add(4'hA, 2, 0, 0, 32'h4, 1);
        add(4'h8, 0, 0, 0, 32'hA, 1);
        add(4'h8, 0, 0, 0, 32'hA, 1);
        add(4'h8, 0, 0, 0, 32'hA, 1);
        add(4'h8, 3, 1, 2, 32'h4, 1);
        add(4'h8, 3, 0, 0, 32'h6, 1);
        add(4'h8, 3, 1, 32'hF, 32'h6, 0);
        add(4'h8, 3, 0, 0, 32'h0, 0);
        add(4'h8, 0, 1, 32'hFFFF_FFFF, 32'h8, 0);
        add(4'h8, 1, 1, 32'hFFFF_FFFF, 32'h0, 0);
        add(4'h8, 1, 0, 0, 32'h0, 0);
        add(4'h8, 2, 1, 32'hFFFF_FFFF, 32'h4, 0);
        add(4'h8, 2, 0, 0, 32'hF, 0);
        add(4'h8, 0, 0, 0, 32'h8, 0);
        add(4'hF, 3, 0, 0, 32'h0, 0);
        add(4'hF, 0, 0, 0, 32'h8, 0);
        add(4'hF, 0, 0, 0, 32'h8, 0);
        add(4'hF, 0, 0, 0, 32'hF, 0);
        add(4'hF, 3, 0, 0, 32'h0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].ip, tbl[i].a, tbl[i].wr, ~tbl[i].wr, tbl[i].wd);
            check($sformatf("vec%0d_readdata", i), readdata, tbl[i].rd);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].irq});
        end

        r_ip = 4'hF;
        for (int n = 0; n < 400; n++) begin
            logic rst, cs, wn;
            logic [1:0] a;
            logic [31:0] wd;
            rst = (n == 0) || ($urandom_range(63) == 0);
            if ($urandom_range(3) == 0) r_ip = 4'($urandom);
            a  = 2'($urandom);
            cs = 1'($urandom);
            wn = ($urandom_range(3) != 0);
            wd = $urandom;
            model_edge(rst, r_ip, a, cs, wn, wd);
            reset = rst;
            step(r_ip, a, cs, wn, wd);
            check($sformatf("rand%0d_readdata", n), readdata, m_rd);
            check($sformatf("rand%0d_irq", n), {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
        end
        reset = 1'b0;
`else
        for (int k = 0; k < 20; k++) begin
            step((k < 5) ? 4'hE : 4'hF, 2'd0, 1'b0, 1'b1, 32'd0);
            check($sformatf("glitch%0d_data", k), readdata, 32'hF);
        end
        step(4'hF, 2'd3, 1'b0, 1'b1, 32'd0);
        check("glitch_edge", readdata, 32'h0);

        for (int k = 0; k < 20; k++) begin
            step(4'hE, 2'd0, 1'b0, 1'b1, 32'd0);
            check($sformatf("accept%0d_data", k), readdata, (k >= 10) ? 32'hE : 32'hF);
        end
        step(4'hE, 2'd3, 1'b0, 1'b1, 32'd0);
        check("accept_edge", readdata, 32'h1);
        check("accept_irq_masked", {31'd0, irq}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
